// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size codes, FSM states and size helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        ERR,
        RESP
    } state_e;

    function automatic logic [3:0] byte_count(input size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response channel from the MEM stage plus the data-memory bus of the LSU.
// The master modport is the LSU itself; slave is the surrounding core and memory.
interface lsu_mem_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_read_data;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_write_data, mem_read, mem_write
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_write_data, mem_read, mem_write
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational data alignment: load extract/extend, store byte merge, alignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       ld_size,
    input  logic        ld_unsigned,
    input  logic [63:0] ld_window,
    output logic [63:0] ld_data,

    input  size_e       st_size,
    input  logic [63:0] st_old,
    input  logic [63:0] st_wdata,
    output logic [63:0] st_merged,

    input  size_e       chk_size,
    input  logic [2:0]  chk_addr,
    output logic        misaligned
);

    always_comb begin
        ld_data = ld_window;
        case (ld_size)
            SZ_B:    ld_data = ld_unsigned ? {56'd0, ld_window[7:0]}
                                           : {{56{ld_window[7]}}, ld_window[7:0]};
            SZ_H:    ld_data = ld_unsigned ? {48'd0, ld_window[15:0]}
                                           : {{48{ld_window[15]}}, ld_window[15:0]};
            SZ_W:    ld_data = ld_unsigned ? {32'd0, ld_window[31:0]}
                                           : {{32{ld_window[31]}}, ld_window[31:0]};
            default: ld_data = ld_window;
        endcase
    end

    // Only the low 2^size bytes come from the store data; the rest of the window is rewritten as read.
    always_comb begin
        st_merged = st_old;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < byte_count(st_size)) begin
                st_merged[i*8 +: 8] = st_wdata[i*8 +: 8];
            end
        end
    end

    assign misaligned = |({1'b0, chk_addr} & (byte_count(chk_size) - 4'd1));

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator for a 64-bit window data memory.
// Sub-doubleword stores are performed as read-modify-write of the addressed window.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input logic             clk,
    input logic             rst_n,
    lsu_mem_master_if.master bus
);

    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES) - 64'd8;

    state_e      state_q, state_d;
    logic        we_q;
    size_e       size_q;
    logic        uns_q;
    logic        err_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] old_q;
    logic [63:0] rdata_q;

    logic        accept;
    logic        misaligned;
    logic        req_err;
    logic [63:0] ld_data;
    logic [63:0] st_merged;
    size_e       req_size;

    assign req_size = size_e'(bus.req_size);
    assign req_err  = misaligned || (bus.req_addr > MAX_ADDR);

    lsu_align u_align (
        .ld_size    (size_q),
        .ld_unsigned(uns_q),
        .ld_window  (bus.mem_read_data),
        .ld_data    (ld_data),
        .st_size    (size_q),
        .st_old     (old_q),
        .st_wdata   (wdata_q),
        .st_merged  (st_merged),
        .chk_size   (req_size),
        .chk_addr   (bus.req_addr[2:0]),
        .misaligned (misaligned)
    );

    // Memory-side outputs depend only on state and captured registers, never on req_*.
    always_comb begin
        state_d            = state_q;
        accept             = 1'b0;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_rdata     = '0;
        bus.resp_err       = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (req_err) begin
                        state_d = ERR;
                    end else if (!bus.req_we || req_size != SZ_D) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            RD: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = addr_q;
                state_d         = we_q ? WR : RESP;
            end
            WR: begin
                bus.mem_write      = 1'b1;
                bus.mem_address    = addr_q;
                bus.mem_write_data = (size_q == SZ_D) ? wdata_q : st_merged;
                state_d            = RESP;
            end
            ERR: begin
                state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_err   = err_q;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.req_we;
                size_q  <= req_size;
                uns_q   <= bus.req_unsigned;
                err_q   <= req_err;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                old_q   <= '0;
                rdata_q <= '0;
            end else if (state_q == RD) begin
                if (we_q) begin
                    old_q <= bus.mem_read_data;
                end else begin
                    rdata_q <= ld_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master against a byte-array model of the data memory.
module tb_lsu_mem_master;
    import lsu_pkg::*;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
        logic [63:0] exp_wd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_clr;
    int   wr_edges = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    lsu_mem_master_if bus ();

    lsu_mem_master #(.MEM_BYTES(1024)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [7:0] mem [1024];

    always_comb begin
        bus.mem_read_data = '0;
        if (bus.mem_address <= 64'd1016) begin
            for (int i = 0; i < 8; i++) begin
                bus.mem_read_data[i*8 +: 8] = mem[bus.mem_address[9:0] + 10'(i)];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (bus.mem_write && bus.mem_address <= 64'd1016) begin
            for (int i = 0; i < 8; i++) begin
                mem[bus.mem_address[9:0] + 10'(i)] <= bus.mem_write_data[i*8 +: 8];
            end
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write) wr_edges <= wr_edges + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"},      64'(bus.req_ready), 64'd1);
        check({tag, " resp_valid"},     64'(bus.resp_valid), 64'd0);
        check({tag, " resp_rdata"},     bus.resp_rdata, 64'd0);
        check({tag, " resp_err"},       64'(bus.resp_err), 64'd0);
        check({tag, " mem_read"},       64'(bus.mem_read), 64'd0);
        check({tag, " mem_write"},      64'(bus.mem_write), 64'd0);
        check({tag, " mem_address"},    bus.mem_address, 64'd0);
        check({tag, " mem_write_data"}, bus.mem_write_data, 64'd0);
    endtask

    task automatic add(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rd, input logic err, input int lat,
                       input int nrd, input int nwr, input logic [63:0] wd);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat;
        v.exp_nrd = nrd; v.exp_nwr = nwr; v.exp_wd = wd;
        vecs.push_back(v);
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [63:0] addr, input logic [63:0] wdata);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat, nrd, nwr, both;
        logic [63:0] wd;
        @(negedge clk);
        check({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
        drive_req(v.we, v.size, v.uns, v.addr, v.wdata);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; both = 0; wd = '0;
        while (!bus.resp_valid && lat < 20) begin
            if (bus.mem_read) nrd++;
            if (bus.mem_write) begin
                nwr++;
                wd = bus.mem_write_data;
            end
            if (bus.mem_read && bus.mem_write) both++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " resp_rdata"}, bus.resp_rdata, v.exp_rdata);
        check({tag, " resp_err"}, 64'(bus.resp_err), 64'(v.exp_err));
        check({tag, " read cycles"}, 64'(nrd), 64'(v.exp_nrd));
        check({tag, " write cycles"}, 64'(nwr), 64'(v.exp_nwr));
        check({tag, " rd+wr overlap"}, 64'(both), 64'd0);
        if (v.exp_nwr != 0) check({tag, " mem_write_data"}, wd, v.exp_wd);
        @(posedge clk);
        #1;
        check({tag, " resp dropped"}, 64'(bus.resp_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int wr0;
        vec_t v;

        rst_n = 1'b0;
        mem_clr = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;

        //  we size uns addr     wdata                   exp_rdata               err lat rd wr exp_wd
        add(1, 3, 0, 64'h10,  64'h1122334455667788, 64'h0,                  0, 1, 0, 1, 64'h1122334455667788);
        add(0, 3, 0, 64'h10,  64'h0,                64'h1122334455667788,   0, 1, 1, 0, 64'h0);
        add(1, 0, 0, 64'h10,  64'hFFFFFFFFFFFFFFAB, 64'h0,                  0, 2, 1, 1, 64'h11223344556677AB);
        add(0, 3, 0, 64'h10,  64'h0,                64'h11223344556677AB,   0, 1, 1, 0, 64'h0);
        add(1, 0, 0, 64'h80,  64'h80,               64'h0,                  0, 2, 1, 1, 64'h80);
        add(0, 0, 0, 64'h80,  64'h0,                64'hFFFFFFFFFFFFFF80,   0, 1, 1, 0, 64'h0);
        add(0, 0, 1, 64'h80,  64'h0,                64'h80,                 0, 1, 1, 0, 64'h0);
        add(0, 2, 0, 64'h12,  64'h0,                64'h0,                  1, 1, 0, 0, 64'h0);
        add(0, 3, 0, 64'd1020, 64'h0,               64'h0,                  1, 1, 0, 0, 64'h0);
        add(0, 2, 0, 64'd1020, 64'h0,               64'h0,                  1, 1, 0, 0, 64'h0);
        add(1, 1, 0, 64'h14,  64'h5555BEEF,         64'h0,                  0, 2, 1, 1, 64'h000000001122BEEF);
        add(0, 1, 0, 64'h14,  64'h0,                64'hFFFFFFFFFFFFBEEF,   0, 1, 1, 0, 64'h0);
        add(0, 1, 1, 64'h14,  64'h0,                64'hBEEF,               0, 1, 1, 0, 64'h0);
        add(0, 2, 0, 64'h14,  64'h0,                64'h000000001122BEEF,   0, 1, 1, 0, 64'h0);
        add(1, 2, 0, 64'h18,  64'hFFFFFFFF80000001, 64'h0,                  0, 2, 1, 1, 64'h0000000080000001);
        add(0, 2, 0, 64'h18,  64'h0,                64'hFFFFFFFF80000001,   0, 1, 1, 0, 64'h0);
        add(0, 2, 1, 64'h18,  64'h0,                64'h80000001,           0, 1, 1, 0, 64'h0);
        add(0, 3, 0, 64'h14,  64'h0,                64'h0,                  1, 1, 0, 0, 64'h0);
        add(1, 1, 0, 64'h11,  64'h7777,             64'h0,                  1, 1, 0, 0, 64'h0);
        add(1, 3, 0, 64'h1C,  64'h7777,             64'h0,                  1, 1, 0, 0, 64'h0);
        add(0, 3, 0, 64'h10,  64'h0,                64'h1122BEEF556677AB,   0, 1, 1, 0, 64'h0);
        add(0, 3, 0, 64'd1016, 64'h0,               64'h0,                  0, 1, 1, 0, 64'h0);
        add(1, 3, 0, 64'd1016, 64'hCAFEF00DDEADBEEF, 64'h0,                 0, 1, 0, 1, 64'hCAFEF00DDEADBEEF);
        add(0, 3, 0, 64'd1016, 64'h0,               64'hCAFEF00DDEADBEEF,   0, 1, 1, 0, 64'h0);
        add(0, 3, 0, 64'd1024, 64'h0,               64'h0,                  1, 1, 0, 0, 64'h0);
        add(1, 0, 0, 64'd1017, 64'h55,              64'h0,                  1, 1, 0, 0, 64'h0);

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        mem_clr = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: response must hold for 5 stalled cycles while the next request waits.
        bus.resp_ready = 1'b0;
        @(negedge clk);
        drive_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        @(posedge clk);
        #1;
        drive_req(1'b0, 2'd0, 1'b0, 64'h10, 64'h0);
        lat = 0;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall latency", 64'(lat), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d resp_valid", k), 64'(bus.resp_valid), 64'd1);
            check($sformatf("stall%0d resp_rdata", k), bus.resp_rdata, 64'h1122BEEF556677AB);
            check($sformatf("stall%0d resp_err", k), 64'(bus.resp_err), 64'd0);
            check($sformatf("stall%0d req_ready", k), 64'(bus.req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release req_ready", 64'(bus.req_ready), 64'd1);
        check("release resp_valid", 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("b2b accepted mem_read", 64'(bus.mem_read), 64'd1);
        check("b2b mem_address", bus.mem_address, 64'h10);
        check("b2b req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("b2b resp_valid", 64'(bus.resp_valid), 64'd1);
        check("b2b resp_rdata", bus.resp_rdata, 64'hFFFFFFFFFFFFFFAB);
        @(posedge clk);
        #1;

        // Reset while a store H sits in its read phase: no write may land.
        @(negedge clk);
        drive_req(1'b1, 2'd1, 1'b0, 64'h10, 64'h1234);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rst-mid in RD", 64'(bus.mem_read), 64'd1);
        wr0 = wr_edges;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst-mid");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst-mid write edges", 64'(wr_edges - wr0), 64'd0);
        check("rst-mid resp_valid", 64'(bus.resp_valid), 64'd0);

        v = vecs[20];
        run_vec(v, "post-reset load D");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
